// File: rtl/wb_merge_if.sv
// wb_merge_if: pipe, long-latency and register-file write signals of the writeback merge stage
interface wb_merge_if #(
  parameter int DEPTH = 4,
  parameter int GRLEN = 32
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic p0_valid;
  logic [4:0] p0_rd;
  logic [GRLEN-1:0] p0_data;
  logic p1_valid;
  logic [4:0] p1_rd;
  logic [GRLEN-1:0] p1_data;
  logic lu_valid;
  logic [4:0] lu_rd;
  logic [GRLEN-1:0] lu_data;
  logic lu_ready;
  logic wen1;
  logic [4:0] waddr1;
  logic [GRLEN-1:0] wdata1;
  logic wen2;
  logic [4:0] waddr2;
  logic [GRLEN-1:0] wdata2;
  logic [31:0] lu_pend_mask;
  logic [CW-1:0] lu_count;
  modport master (
    output p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data, lu_valid, lu_rd, lu_data,
    input lu_ready, wen1, waddr1, wdata1, wen2, waddr2, wdata2, lu_pend_mask, lu_count
  );
  modport slave (
    input p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data, lu_valid, lu_rd, lu_data,
    output lu_ready, wen1, waddr1, wdata1, wen2, waddr2, wdata2, lu_pend_mask, lu_count
  );
endinterface

// File: rtl/wb_merge.sv
// wb_merge: pipe results pass straight to the write ports; long-latency results queue and fill idle ports
module wb_merge #(
  parameter int DEPTH = 4,
  parameter int GRLEN = 32
) (
  input logic clk,
  input logic rst,
  wb_merge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0] rd_q [DEPTH];
  logic [GRLEN-1:0] data_q [DEPTH];
  logic [AW-1:0] head, tail, head1, head_n;
  logic [CW-1:0] count, count_n, pops;
  logic [31:0] mask, mask_n;
  logic p0_ok, p1_ok, has0, has1, pop_a, pop_b, push;
  always_comb begin
    p0_ok = bus.p0_valid && bus.p0_rd != 5'd0;
    p1_ok = bus.p1_valid && bus.p1_rd != 5'd0;
    has0 = count != '0;
    has1 = count > CW'(1);
    head1 = head + AW'(1);
    pop_a = has0 && !(p0_ok && p1_ok);
    pop_b = has1 && !p0_ok && !p1_ok;
    pops = CW'(pop_a) + CW'(pop_b);
    push = bus.lu_valid && bus.lu_ready && bus.lu_rd != 5'd0;
    count_n = count + CW'(push) - pops;
    head_n = head + pops[AW-1:0];
    mask_n = '0;
    for (int i = 0; i < DEPTH; i++)
      mask_n |= CW'(i) < count_n ? 32'(1) << (push && head_n + AW'(i) == tail ? bus.lu_rd : rd_q[head_n + AW'(i)]) : '0;
  end
  assign bus.lu_ready = count < CW'(DEPTH);
  assign bus.lu_count = count;
  assign bus.lu_pend_mask = mask;
  assign bus.wen1 = p0_ok || has0;
  assign bus.waddr1 = p0_ok ? bus.p0_rd : rd_q[head];
  assign bus.wdata1 = p0_ok ? bus.p0_data : data_q[head];
  assign bus.wen2 = p1_ok || (p0_ok ? has0 : has1);
  assign bus.waddr2 = p1_ok ? bus.p1_rd : p0_ok ? rd_q[head] : rd_q[head1];
  assign bus.wdata2 = p1_ok ? bus.p1_data : p0_ok ? data_q[head] : data_q[head1];
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      mask <= '0;
    end else begin
      if (push) begin
        rd_q[tail] <= bus.lu_rd;
        data_q[tail] <= bus.lu_data;
        tail <= tail + AW'(1);
      end
      head <= head_n;
      count <= count_n;
      mask <= mask_n;
    end
  end
endmodule
